// File: rtl/tone_pkg.sv
// Shared types and melody constants for the keylock tone sequencer.
// Half-periods are in 12 MHz hwclk cycles.
package tone_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NOTE = 2'd1,
        GAP  = 2'd2
    } state_t;

    typedef enum logic {
        MEL_OK  = 1'b0,
        MEL_ERR = 1'b1
    } mel_t;

    // ACCEPT: 1 kHz, 1.33 kHz, 2 kHz; REJECT: 500 Hz twice
    localparam logic [31:0] HP_OK_0 = 32'd6000;
    localparam logic [31:0] HP_OK_1 = 32'd4500;
    localparam logic [31:0] HP_OK_2 = 32'd3000;
    localparam logic [31:0] HP_ERR  = 32'd12000;

    localparam logic [1:0] LEN_OK  = 2'd3;
    localparam logic [1:0] LEN_ERR = 2'd2;

endpackage

// File: rtl/tone_rom.sv
// Combinational melody lookup: (melody, note index) -> half-period and last-note flag.
// Out-of-range indices read as silent and last so a stray index always terminates.
module tone_rom
    import tone_pkg::*;
#(
    parameter int unsigned HP_WIDTH = 32
) (
    input  mel_t                mel,
    input  logic [1:0]          idx,
    output logic [HP_WIDTH-1:0] halfperiod,
    output logic                is_last
);

    logic [31:0] hp_s;
    logic [1:0]  len_s;

    // Note table and melody length lookup
    always_comb begin
        hp_s  = 32'd0;
        len_s = LEN_OK;
        case (mel)
            MEL_OK: begin
                len_s = LEN_OK;
                case (idx)
                    2'd0:    hp_s = HP_OK_0;
                    2'd1:    hp_s = HP_OK_1;
                    2'd2:    hp_s = HP_OK_2;
                    default: hp_s = 32'd0;
                endcase
            end
            MEL_ERR: begin
                len_s = LEN_ERR;
                case (idx)
                    2'd0:    hp_s = HP_ERR;
                    2'd1:    hp_s = HP_ERR;
                    default: hp_s = 32'd0;
                endcase
            end
            default: begin
                len_s = LEN_OK;
                hp_s  = 32'd0;
            end
        endcase
        halfperiod = HP_WIDTH'(hp_s);
        is_last    = (idx >= (len_s - 2'd1));
    end

endmodule

// File: rtl/tone_sequencer.sv
// Plays the ACCEPT / REJECT buzzer melody on a one-cycle trigger.
// Emits a registered half-period + tone enable per note, busy while playing, done at the end.
module tone_sequencer
    import tone_pkg::*;
#(
    parameter int unsigned NOTE_CYCLES = 2_400_000,
    parameter int unsigned GAP_CYCLES  = 600_000,
    parameter int unsigned HP_WIDTH    = 32
) (
    input  logic                hwclk,
    input  logic                rst,
    input  logic                play_ok,
    input  logic                play_err,
    output logic [HP_WIDTH-1:0] tone_halfperiod,
    output logic                tone_en,
    output logic                busy,
    output logic                done
);

    localparam logic [31:0] NOTE_TC = 32'(NOTE_CYCLES - 32'd1);
    localparam logic [31:0] GAP_TC  = 32'(GAP_CYCLES - 32'd1);

    state_t              state_r, state_s;
    logic [31:0]         cnt_r, cnt_s;
    logic [1:0]          idx_r, idx_s;
    mel_t                mel_r, mel_s;
    logic                is_last_r;
    logic                done_s;
    logic [HP_WIDTH-1:0] rom_hp_s;
    logic                rom_last_s;
    logic [HP_WIDTH-1:0] hp_r;
    logic                tone_en_r, busy_r, done_r;

    // ROM is addressed with the next note so its value can be registered on entry
    tone_rom #(.HP_WIDTH(HP_WIDTH)) u_rom (
        .mel        (mel_s),
        .idx        (idx_s),
        .halfperiod (rom_hp_s),
        .is_last    (rom_last_s)
    );

    // Next-state, counter, index and melody-select logic
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r + 32'd1;
        idx_s   = idx_r;
        mel_s   = mel_r;
        done_s  = 1'b0;
        case (state_r)
            IDLE: begin
                cnt_s = 32'd0;
                idx_s = 2'd0;
                if (play_err) begin
                    mel_s   = MEL_ERR;
                    state_s = NOTE;
                end else if (play_ok) begin
                    mel_s   = MEL_OK;
                    state_s = NOTE;
                end else begin
                    state_s = IDLE;
                end
            end
            NOTE: begin
                if (play_err && (mel_r == MEL_OK)) begin
                    mel_s   = MEL_ERR;
                    idx_s   = 2'd0;
                    cnt_s   = 32'd0;
                    state_s = NOTE;
                end else if (cnt_r == NOTE_TC) begin
                    cnt_s   = 32'd0;
                    state_s = GAP;
                end else begin
                    state_s = NOTE;
                end
            end
            GAP: begin
                // REJECT preempts ACCEPT even on the final gap cycle, so no done then
                if (play_err && (mel_r == MEL_OK)) begin
                    mel_s   = MEL_ERR;
                    idx_s   = 2'd0;
                    cnt_s   = 32'd0;
                    state_s = NOTE;
                end else if (cnt_r == GAP_TC) begin
                    cnt_s = 32'd0;
                    if (is_last_r) begin
                        idx_s   = 2'd0;
                        done_s  = 1'b1;
                        state_s = IDLE;
                    end else begin
                        idx_s   = idx_r + 2'd1;
                        state_s = NOTE;
                    end
                end else begin
                    state_s = GAP;
                end
            end
            default: begin
                cnt_s   = 32'd0;
                idx_s   = 2'd0;
                state_s = IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge hwclk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            cnt_r     <= 32'd0;
            idx_r     <= 2'd0;
            mel_r     <= MEL_OK;
            is_last_r <= 1'b0;
            hp_r      <= {HP_WIDTH{1'b0}};
            tone_en_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            idx_r     <= idx_s;
            mel_r     <= mel_s;
            is_last_r <= rom_last_s;
            hp_r      <= (state_s == NOTE) ? rom_hp_s : {HP_WIDTH{1'b0}};
            tone_en_r <= (state_s == NOTE);
            busy_r    <= (state_s != IDLE);
            done_r    <= done_s;
        end
    end

    assign tone_halfperiod = hp_r;
    assign tone_en         = tone_en_r;
    assign busy            = busy_r;
    assign done            = done_r;

endmodule

// File: tb/tb_tone_sequencer.sv
// Bench for tone_sequencer: melody-timeline model checked every cycle, directed
// scenarios with literal expectations, then randomized triggers and resets.
module tb_tone_sequencer;

    localparam int NOTE = 8;
    localparam int GAPC = 4;
    localparam int PER  = NOTE + GAPC;

    logic        hwclk;
    logic        rst;
    logic        play_ok;
    logic        play_err;
    logic [31:0] tone_halfperiod;
    logic        tone_en;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_bad = 0;

    int mel_hp [2][3] = '{'{6000, 4500, 3000}, '{12000, 12000, 0}};
    int mel_len [2]   = '{3, 2};

    // Model: a melody is "active" with an elapsed cycle count since its first note cycle
    bit m_active = 1'b0;
    int m_mel    = 0;
    int m_el     = 0;
    bit m_done   = 1'b0;

    tone_sequencer #(
        .NOTE_CYCLES (NOTE),
        .GAP_CYCLES  (GAPC),
        .HP_WIDTH    (32)
    ) dut (
        .hwclk           (hwclk),
        .rst             (rst),
        .play_ok         (play_ok),
        .play_err        (play_err),
        .tone_halfperiod (tone_halfperiod),
        .tone_en         (tone_en),
        .busy            (busy),
        .done            (done)
    );

    initial hwclk = 1'b0;
    always #5 hwclk = ~hwclk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle model update and comparison
    initial begin
        int exp_hp;
        bit exp_en;
        forever begin
            @(posedge hwclk);
            m_done = 1'b0;
            if (rst) begin
                m_active = 1'b0;
            end else if (m_active) begin
                if (play_err && m_mel == 0) begin
                    m_mel = 1;
                    m_el  = 0;
                end else begin
                    m_el++;
                    if (m_el == mel_len[m_mel] * PER) begin
                        m_active = 1'b0;
                        m_done   = 1'b1;
                    end
                end
            end else if (play_err) begin
                m_active = 1'b1; m_mel = 1; m_el = 0;
            end else if (play_ok) begin
                m_active = 1'b1; m_mel = 0; m_el = 0;
            end
            exp_en = m_active && ((m_el % PER) < NOTE);
            exp_hp = exp_en ? mel_hp[m_mel][m_el / PER] : 0;
            #1;
            chk("cyc_tone_en", {31'd0, tone_en}, {31'd0, exp_en});
            chk("cyc_halfperiod", tone_halfperiod, exp_hp);
            chk("cyc_busy", {31'd0, busy}, {31'd0, m_active});
            chk("cyc_done", {31'd0, done}, {31'd0, m_done});
        end
    end

    // Pulse triggers for one cycle; returns at the negedge of the first response cycle
    task automatic trig(input bit ok, input bit err);
        @(negedge hwclk);
        play_ok  = ok;
        play_err = err;
        @(negedge hwclk);
        play_ok  = 1'b0;
        play_err = 1'b0;
    endtask

    task automatic chk_quiet(input string nm);
        chk({nm, "_hp"}, tone_halfperiod, 32'd0);
        chk({nm, "_en"}, {31'd0, tone_en}, 32'd0);
        chk({nm, "_busy"}, {31'd0, busy}, 32'd0);
        chk({nm, "_done"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; play_ok = 1'b0; play_err = 1'b0;

        // Reset held while triggers toggle
        for (int i = 0; i < 4; i++) begin
            @(negedge hwclk);
            play_ok  = i[0];
            play_err = ~i[0];
        end
        @(negedge hwclk);
        play_ok = 1'b0; play_err = 1'b0;
        chk_quiet("rst_held");
        rst = 1'b0;
        repeat (3) @(negedge hwclk);
        chk_quiet("post_rst");

        // ACCEPT timeline
        trig(1'b1, 1'b0);
        chk("ok_n1_en", {31'd0, tone_en}, 32'd1);
        chk("ok_n1_hp", tone_halfperiod, 32'd6000);
        chk("ok_n1_busy", {31'd0, busy}, 32'd1);
        repeat (8) @(negedge hwclk);
        chk("ok_gap1_en", {31'd0, tone_en}, 32'd0);
        chk("ok_gap1_hp", tone_halfperiod, 32'd0);
        repeat (4) @(negedge hwclk);
        chk("ok_n2_hp", tone_halfperiod, 32'd4500);
        repeat (12) @(negedge hwclk);
        chk("ok_n3_hp", tone_halfperiod, 32'd3000);
        repeat (11) @(negedge hwclk);
        chk("ok_n36_busy", {31'd0, busy}, 32'd1);
        chk("ok_n36_done", {31'd0, done}, 32'd0);
        repeat (1) @(negedge hwclk);
        chk("ok_n37_done", {31'd0, done}, 32'd1);
        chk("ok_n37_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge hwclk);

        // Simultaneous triggers: REJECT wins
        trig(1'b1, 1'b1);
        chk("both_hp", tone_halfperiod, 32'd12000);
        repeat (24) @(negedge hwclk);
        chk("both_done", {31'd0, done}, 32'd1);
        chk("both_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge hwclk);

        // REJECT preempts ACCEPT during note 2
        trig(1'b1, 1'b0);
        repeat (13) @(negedge hwclk);
        chk("pre_n2_hp", tone_halfperiod, 32'd4500);
        trig(1'b0, 1'b1);
        chk("pre_hp", tone_halfperiod, 32'd12000);
        chk("pre_busy", {31'd0, busy}, 32'd1);
        repeat (23) @(negedge hwclk);
        chk("pre_done_early", {31'd0, done}, 32'd0);
        repeat (1) @(negedge hwclk);
        chk("pre_done", {31'd0, done}, 32'd1);
        repeat (3) @(negedge hwclk);

        // Triggers during REJECT are ignored
        trig(1'b0, 1'b1);
        repeat (3) @(negedge hwclk);
        trig(1'b1, 1'b0);
        repeat (5) @(negedge hwclk);
        trig(1'b0, 1'b1);
        chk("ign_n2_hp", tone_halfperiod, 32'd12000);
        chk("ign_n2_en", {31'd0, tone_en}, 32'd1);
        repeat (11) @(negedge hwclk);
        chk("ign_done_early", {31'd0, done}, 32'd0);
        repeat (1) @(negedge hwclk);
        chk("ign_done", {31'd0, done}, 32'd1);
        repeat (3) @(negedge hwclk);

        // Async reset during an ACCEPT gap
        trig(1'b1, 1'b0);
        repeat (9) @(negedge hwclk);
        rst = 1'b1;
        #1;
        chk_quiet("async_rst");
        repeat (2) @(negedge hwclk);
        rst = 1'b0;
        repeat (2) @(negedge hwclk);
        trig(1'b1, 1'b0);
        chk("after_rst_hp", tone_halfperiod, 32'd6000);
        repeat (40) @(negedge hwclk);

        // Randomized triggers and occasional resets, checked by the model
        for (int c = 0; c < 3000; c++) begin
            @(negedge hwclk);
            play_ok  = ($urandom_range(0, 19) == 0);
            play_err = ($urandom_range(0, 39) == 0);
            rst      = ($urandom_range(0, 299) == 0);
        end
        @(negedge hwclk);
        play_ok = 1'b0; play_err = 1'b0; rst = 1'b0;
        repeat (50) @(negedge hwclk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
